if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the 5-stage pipelined CPU: holds the program counter, drives the instruction-memory read address, and registers the fetched instruction into the IF/ID pipeline register. It sits directly upstream of the decode stage and is steered by the hazard-detection unit (stall) and the ID-stage branch logic (flush/target). An optional performance block counts stall and flush cycles so the bench reads them from one place.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000: encoding injected into IF/ID on flush or bubble.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  run enable; PC advances only while high.
- stall_i  in  1  hazard stall from hazard-detection unit.
- flush_i  in  1  branch taken, resolved in ID.
- branch_target_i  in  32  target PC, valid when flush_i=1.
- imem_addr_o  out  32  instruction-memory byte address (= pc_o).
- imem_instr_i  in  32  instruction read combinationally at imem_addr_o.
- pc_o  out  32  current PC register.
- ifid_pc_o  out  32  PC of instruction held in IF/ID.
- ifid_instr_o  out  32  instruction held in IF/ID.
- ifid_valid_o  out  1  IF/ID holds a real instruction (0 = bubble).
- stall_cnt_o  out  32  stall-cycle count.
- flush_cnt_o  out  32  flush-cycle count.

## Operation
- States: IDLE, RUN. Reset -> IDLE. IDLE -> RUN when start_i=1 at a clock edge. RUN -> IDLE when start_i=0 at a clock edge.
- Reset values: pc_o=RESET_PC, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, both counters 0. rst_i overrides every other input.
- imem_addr_o = pc_o, combinational.
- Per-edge priority in RUN: flush > stall > advance.
  - flush_i=1: pc <= branch_target_i; IF/ID <= {pc_o, NOP_INSTR, valid 0}. Applies even if stall_i=1.
  - stall_i=1, flush_i=0: pc and IF/ID hold (all three IF/ID fields unchanged).
  - otherwise: pc <= pc_o + 4; IF/ID <= {pc_o, imem_instr_i, valid 1}.
- IDLE (including the edge that leaves IDLE): pc holds; IF/ID <= bubble (NOP_INSTR, valid 0, ifid_pc_o unchanged). stall_i/flush_i ignored.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. branch_target_i is taken verbatim; bits [1:0] are not forced.
- Counters (RUN only): stall_cnt increments when stall_i=1 && flush_i=0; flush_cnt increments when flush_i=1. Both wrap 32'hFFFF_FFFF -> 0. Neither counts in IDLE.

## Timing
- PC-to-IF/ID latency: 1 cycle; the instruction fetched at PC=P appears on ifid_instr_o one edge after pc_o=P.
- Branch penalty: 1 bubble; the edge with flush_i=1 loads the target and the next edge fetches it.
- Stall releases immediately: the first edge with stall_i=0 advances normally.
- Reset mid-run: on the edge with rst_i=1 all state takes reset values; in-flight IF/ID contents are dropped; state goes to IDLE even if start_i=1. RUN resumes on the first edge with rst_i=0 and start_i=1, and that edge inserts a bubble.
- Counter outputs are registered and reflect events up to the previous edge.

## Configuration
- IF_STAGE_PERF_CNT_EN defined: stall_cnt_o/flush_cnt_o are live counters as above.
- Not defined: the counter registers are not built; stall_cnt_o and flush_cnt_o are tied to 32'h0. Ports are kept so the CPU top-level is unchanged. Fetch behaviour is identical either way.

## Test plan
- Reset then start_i=1 with imem word i = i+1 at byte address 4i, no stall/flush: pc_o sequence 0, 0, 4, 8, 12, where the first edge out of IDLE holds the PC. ifid_instr_o gives a bubble, then 1, 2, 3, with ifid_valid_o=1 from the third edge.
- Steady run at pc_o=8, stall_i=1 for 2 cycles: pc_o stays 8 and IF/ID holds {4, instr@4, 1} for both cycles. On release, pc_o=12. stall_cnt_o=2.
- At pc_o=16, flush_i=1 with branch_target_i=64: next pc_o=64, ifid_instr_o=NOP_INSTR, ifid_valid_o=0. The following edge gives pc_o=68 and ifid_pc_o=64. flush_cnt_o=1.
- flush_i=1 and stall_i=1 on the same edge with target 32: pc_o=32, bubble in IF/ID, flush_cnt_o +1, stall_cnt_o unchanged.
- rst_i=1 for one edge while at pc_o=40 with start_i=1 held: pc_o=0, ifid_valid_o=0, counters 0. The next edge is a bubble and pc_o stays 0; the edge after that gives pc_o=4.
- PC wrap: force branch_target_i=32'hFFFF_FFFC via flush, then advance: pc_o goes 32'hFFFF_FFFC then 0. With IF_STAGE_PERF_CNT_EN undefined, repeating the first four scenarios gives identical fetch results and counters read 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage pipeline.
// Holds the PC, drives the instruction-memory address and registers the
// fetched word into the IF/ID pipeline register. Flush (taken branch from ID)
// beats stall (hazard unit), which beats a normal advance.
// Optional macro IF_STAGE_PERF_CNT_EN builds the stall/flush cycle counters;
// without it stall_cnt_o/flush_cnt_o read 32'h0.
//
// Handshake: ifid_valid_o is the IF/ID "valid" toward decode. There is no
// ready wire; stall_i acts as the inverted ready. While stall_i=1 (and no
// flush) the IF/ID contents are held unchanged, so decode sees the same
// instruction until the first edge with stall_i=0.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic        dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    // Next-state and next-PC / IF/ID selection; defaults hold everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        case (state_q)
            IDLE: begin
                // PC holds and a bubble enters IF/ID, including the edge that
                // leaves IDLE; stall/flush are ignored here.
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (flush_i) begin
                    // Wrong-path word at pc_q is squashed; fetch resumes at target.
                    pc_d         = branch_target_i;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else if (!stall_i) begin
                    pc_d         = pc_q + 32'd4;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_instr_i;
                    ifid_valid_d = 1'b1;
                end
                if (!start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Performance counters: only RUN cycles count; a stall hidden by a flush
    // is a flush cycle, not a stall cycle. Both wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
        end else if (state_q == RUN) begin
            if (flush_i) flush_cnt_q <= flush_cnt_q + 32'd1;
            else if (stall_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'h0000_0000;
    assign flush_cnt_o = 32'h0000_0000;
`endif

    assign pc_o         = pc_q;
    assign imem_addr_o  = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign dbg_state_o  = (state_q == RUN);

endmodule
